// File: rtl/seven_seg_scan_ctrl.sv
// Multiplexed 7-seg scan controller with double-buffered BCD value.
// Optional: LEADING_ZERO_BLANK_EN blanks slots above the top nonzero digit.
module seven_seg_scan_ctrl #(
  parameter int N_DIGITS = 4,
  parameter int REFRESH_DIV = 100000,
  parameter int GAP_CYCLES = 4,
  parameter logic [3:0] PH_CODE = 4'hF,
  localparam int SW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1,
  localparam int DW = 4 * N_DIGITS
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic          load_valid,
  input  logic [DW-1:0] load_data,
  output logic          load_ready,
  output logic [3:0]    dig_code,
  output logic [N_DIGITS-1:0] an,
  output logic [SW-1:0] dig_sel,
  output logic          frame_tick
);

  localparam int CW = $clog2(REFRESH_DIV);
  localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] GAP_LAST = CW'(GAP_CYCLES - 1);
  localparam logic [SW-1:0] SEL_LAST = SW'(N_DIGITS - 1);

  typedef enum logic [1:0] {
    S_OFF,
    S_GAP,
    S_ON
  } state_t;

  localparam state_t S_START = (GAP_CYCLES == 0) ? S_ON : S_GAP;

  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [SW-1:0] sel_n;
  logic [DW-1:0] disp, disp_n;
  logic [DW-1:0] shadow, shadow_n;
  logic pending, pending_n;
  logic [N_DIGITS-1:0] an_n;
  logic [3:0] code_n;
  logic tick_n;
  logic lit;
`ifdef LEADING_ZERO_BLANK_EN
  logic [SW-1:0] msd;
`endif

  always_comb begin
    state_n = state;
    cnt_n = cnt;
    sel_n = dig_sel;
    if (!en) begin
      state_n = S_OFF;
      cnt_n = '0;
      sel_n = '0;
    end else begin
      unique case (state)
        S_OFF: begin
          state_n = S_START;
          cnt_n = '0;
          sel_n = '0;
        end
        S_GAP: begin
          cnt_n = cnt + 1'b1;
          if (cnt == GAP_LAST) state_n = S_ON;
        end
        S_ON: begin
          if (cnt == CNT_LAST) begin
            cnt_n = '0;
            state_n = S_START;
            sel_n = (dig_sel == SEL_LAST) ? '0 : dig_sel + 1'b1;
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
        default: begin
          state_n = S_OFF;
          cnt_n = '0;
          sel_n = '0;
        end
      endcase
    end
  end

  // pending gates load_ready, so a swap and a transfer never coincide
  always_comb begin
    disp_n = disp;
    shadow_n = shadow;
    pending_n = pending;
    if (frame_tick && pending) begin
      disp_n = shadow;
      pending_n = 1'b0;
    end else if (load_valid && load_ready) begin
      shadow_n = load_data;
      pending_n = 1'b1;
    end
  end

  always_comb begin
    lit = 1'b1;
`ifdef LEADING_ZERO_BLANK_EN
    msd = '0;
    for (int i = 1; i < N_DIGITS; i++) begin
      if (disp_n[4*i +: 4] != 4'h0) msd = SW'(i);
    end
    lit = (sel_n <= msd);
`endif
    an_n = '1;
    code_n = PH_CODE;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (sel_n == SW'(i)) begin
        code_n = disp_n[4*i +: 4];
        an_n[i] = !((state_n == S_ON) && lit);
      end
    end
    tick_n = (state_n == S_ON) && (sel_n == SEL_LAST) &&
             (cnt_n == CNT_LAST);
  end

  // outputs are registered from next-state values so they align with state
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_OFF;
      cnt <= '0;
      dig_sel <= '0;
      disp <= {N_DIGITS{PH_CODE}};
      shadow <= {N_DIGITS{PH_CODE}};
      pending <= 1'b0;
      an <= '1;
      dig_code <= PH_CODE;
      frame_tick <= 1'b0;
      load_ready <= 1'b1;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      dig_sel <= sel_n;
      disp <= disp_n;
      shadow <= shadow_n;
      pending <= pending_n;
      an <= an_n;
      dig_code <= code_n;
      frame_tick <= tick_n;
      load_ready <= !pending_n;
    end
  end

endmodule
